// File: rtl/fat_chain_scheduler_pkg.sv
// Shared types and constants for the FAT chain scheduler.
package fat_pkg;

  // End-of-chain marker the updater writes at the final cluster.
  localparam logic [31:0] FAT_EOF = 32'h0FFF_FFFF;
  // Clusters 0 and 1 are reserved; a chain may not begin below this.
  localparam logic [31:0] FAT_MIN_CLUST = 32'd2;

  typedef logic [31:0] clust_t;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StLoad,
    StUpdate,
    StFlush,
    StNext,
    StFin
  } state_e;

endpackage

// File: rtl/fat_chain_scheduler_if.sv
// Control, FAT-updater and media handshakes of the chain scheduler.
interface fat_chain_scheduler_if;
  import fat_pkg::*;

  // File-write control side
  logic        start;
  clust_t      begin_clust;
  clust_t      end_clust;
  logic        busy;
  logic        done;
  logic        err;
  // FAT updater side
  logic        upd_ena;
  clust_t      upd_begin;
  clust_t      upd_end;
  logic        upd_last;
  logic        upd_complt;
  // Media side
  logic        med_rd_req;
  logic        med_wr_req;
  logic [31:0] med_lba;
  logic        med_ack;

  // Environment view: issues requests, plays updater and media.
  modport master (
    output start, begin_clust, end_clust, upd_complt, med_ack,
    input  busy, done, err, upd_ena, upd_begin, upd_end, upd_last,
    input  med_rd_req, med_wr_req, med_lba
  );

  // Scheduler view.
  modport slave (
    input  start, begin_clust, end_clust, upd_complt, med_ack,
    output busy, done, err, upd_ena, upd_begin, upd_end, upd_last,
    output med_rd_req, med_wr_req, med_lba
  );

endinterface

// File: rtl/fat_chain_scheduler_seg_calc.sv
// Page-local segment bounds and media LBA for the current cluster and FAT copy.
module fat_seg_calc
  import fat_pkg::*;
#(
  parameter logic [31:0] FAT_BASE_LBA  = 32'h20,
  parameter logic [31:0] FAT_SIZE_SECT = 32'h3C0,
  parameter int unsigned PAGE_LOG2     = 10,
  parameter int unsigned SECT_PER_PAGE = 8
) (
  input  clust_t      cur,
  input  clust_t      end_clust,
  input  logic [1:0]  copy,
  output clust_t      seg_end,
  output logic        last,
  output logic [31:0] lba
);

  clust_t page;
  clust_t page_last;

  // Clip the segment at the end of the page holding cur; LBA wraps mod 2^32.
  always_comb begin
    page      = cur >> PAGE_LOG2;
    page_last = (page << PAGE_LOG2) | ((32'd1 << PAGE_LOG2) - 32'd1);
    seg_end   = (end_clust < page_last) ? end_clust : page_last;
    last      = (seg_end == end_clust);
    lba       = FAT_BASE_LBA + page * SECT_PER_PAGE + 32'(copy) * FAT_SIZE_SECT;
  end

endmodule

// File: rtl/fat_chain_scheduler.sv
// Read-modify-write sequencer: load page, run FAT updater, flush to every FAT copy.
module fat_chain_scheduler
  import fat_pkg::*;
#(
  parameter logic [31:0] FAT_BASE_LBA  = 32'h20,
  parameter logic [31:0] FAT_SIZE_SECT = 32'h3C0,
  parameter int unsigned PAGE_LOG2     = 10,
  parameter int unsigned SECT_PER_PAGE = 8,
  parameter int unsigned NUM_FATS      = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  fat_chain_scheduler_if.slave bus
);

  state_e     state_q, state_d;
  clust_t     cur_q, cur_d;
  clust_t     end_q, end_d;
  logic [1:0] copy_q, copy_d;
  logic       err_q, err_d;
  // UPD_ENA trails the segment values by one cycle.
  logic       ena_q, ena_d;
  // One-cycle request gap between consecutive FAT-copy writes.
  logic       gap_q, gap_d;

  clust_t      seg_end;
  logic        seg_last;
  logic [31:0] seg_lba;

  logic        busy, done, upd_ena, upd_last, rd_req, wr_req;
  clust_t      upd_begin, upd_end;
  logic [31:0] med_lba;

  fat_seg_calc #(
    .FAT_BASE_LBA  (FAT_BASE_LBA),
    .FAT_SIZE_SECT (FAT_SIZE_SECT),
    .PAGE_LOG2     (PAGE_LOG2),
    .SECT_PER_PAGE (SECT_PER_PAGE)
  ) u_seg_calc (
    .cur       (cur_q),
    .end_clust (end_q),
    .copy      (copy_q),
    .seg_end   (seg_end),
    .last      (seg_last),
    .lba       (seg_lba)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cur_q   <= '0;
      end_q   <= '0;
      copy_q  <= '0;
      err_q   <= 1'b0;
      ena_q   <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      end_q   <= end_d;
      copy_q  <= copy_d;
      err_q   <= err_d;
      ena_q   <= ena_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    end_d   = end_q;
    copy_d  = copy_q;
    err_d   = err_q;
    ena_d   = ena_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          cur_d   = bus.begin_clust;
          end_d   = bus.end_clust;
          copy_d  = '0;
          err_d   = 1'b0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (cur_q < FAT_MIN_CLUST || cur_q > end_q) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (bus.med_ack) begin
          ena_d   = 1'b0;
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        if (!ena_q) begin
          ena_d = 1'b1;
        end else if (bus.upd_complt) begin
          ena_d   = 1'b0;
          copy_d  = '0;
          gap_d   = 1'b0;
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (bus.med_ack) begin
          if (32'(copy_q) < NUM_FATS - 1) begin
            copy_d = copy_q + 2'd1;
            gap_d  = 1'b1;
          end else begin
            state_d = StNext;
          end
        end
      end
      StNext: begin
        // Reads always come from copy 0.
        copy_d = '0;
        if (seg_last) begin
          state_d = StFin;
        end else begin
          cur_d   = seg_end + 32'd1;
          state_d = StLoad;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from registered state only, so reset clears them at once.
  always_comb begin
    busy      = (state_q != StIdle) && (state_q != StFin);
    done      = (state_q == StFin);
    rd_req    = (state_q == StLoad);
    wr_req    = (state_q == StFlush) && !gap_q;
    upd_ena   = (state_q == StUpdate) && ena_q;
    upd_begin = (state_q == StUpdate) ? cur_q : '0;
    upd_end   = (state_q == StUpdate) ? seg_end : '0;
    upd_last  = (state_q == StUpdate) && seg_last;
    med_lba   = (rd_req || wr_req) ? seg_lba : '0;
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.err        = err_q;
  assign bus.upd_ena    = upd_ena;
  assign bus.upd_begin  = upd_begin;
  assign bus.upd_end    = upd_end;
  assign bus.upd_last   = upd_last;
  assign bus.med_rd_req = rd_req;
  assign bus.med_wr_req = wr_req;
  assign bus.med_lba    = med_lba;

endmodule

// File: tb/tb_fat_chain_scheduler.sv
// Directed bench for fat_chain_scheduler with media and updater responders.
module tb_fat_chain_scheduler;
  import fat_pkg::*;

  localparam int Timeout = 3000;

  logic clk;
  logic rst_n;
  logic ack_auto, ack_man;
  int   n_pass, n_total;

  // Responder knobs
  int   med_delay, upd_delay;
  bit   upd_auto;

  // Monitor logs: event = {kind, a, b, last}; kind 0=RD 1=WR 2=UPD
  logic [66:0] ev_q[$];
  int   viol, act, done_cnt, rd_cycles;

  fat_chain_scheduler_if bus ();

  fat_chain_scheduler u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.med_ack = ack_auto | ack_man;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [66:0] ev(input int k, input logic [31:0] a, input logic [31:0] b,
                                      input logic l);
    return {2'(k), a, b, l};
  endfunction

  function automatic logic [102:0] outs();
    return {bus.busy, bus.done, bus.err, bus.upd_ena, bus.upd_begin, bus.upd_end,
            bus.upd_last, bus.med_rd_req, bus.med_wr_req, bus.med_lba};
  endfunction

  // Media responder: ack after med_delay cycles of a held request.
  initial begin
    int cnt;
    cnt = 0;
    ack_auto = 1'b0;
    forever begin
      @(negedge clk);
      ack_auto = 1'b0;
      if (bus.med_rd_req || bus.med_wr_req) begin
        if (cnt >= med_delay) begin
          ack_auto = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Updater responder.
  initial begin
    int cnt;
    cnt = 0;
    bus.upd_complt = 1'b0;
    forever begin
      @(negedge clk);
      bus.upd_complt = 1'b0;
      if (upd_auto && bus.upd_ena) begin
        if (cnt >= upd_delay) begin
          bus.upd_complt = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: log request/updater rising edges and protocol violations.
  initial begin
    logic        p_rd, p_wr, p_ena;
    logic [31:0] p_lba;
    logic [64:0] p_upd, c_upd;
    p_rd = 0; p_wr = 0; p_ena = 0; p_lba = '0; p_upd = '0;
    forever begin
      @(negedge clk);
      c_upd = {bus.upd_begin, bus.upd_end, bus.upd_last};
      if (bus.med_rd_req && bus.med_wr_req) viol++;
      if (bus.med_rd_req || bus.med_wr_req || bus.upd_ena) act++;
      if (bus.med_rd_req) rd_cycles++;
      if (bus.med_rd_req && !p_rd) ev_q.push_back({2'd0, bus.med_lba, 32'd0, 1'b0});
      if (bus.med_wr_req && !p_wr) ev_q.push_back({2'd1, bus.med_lba, 32'd0, 1'b0});
      if ((bus.med_rd_req && p_rd || bus.med_wr_req && p_wr) && bus.med_lba !== p_lba) viol++;
      if (bus.upd_ena && !p_ena) ev_q.push_back({2'd2, c_upd});
      // Values must be stable the cycle before ENA rises and while it is high.
      if (bus.upd_ena && c_upd !== p_upd) viol++;
      if (bus.done) done_cnt++;
      if (bus.done && bus.busy) viol++;
      p_rd = bus.med_rd_req; p_wr = bus.med_wr_req; p_ena = bus.upd_ena;
      p_lba = bus.med_lba; p_upd = c_upd;
    end
  end

  task automatic clear_logs();
    ev_q.delete();
    viol = 0; act = 0; done_cnt = 0; rd_cycles = 0;
  endtask

  task automatic run_chain(input logic [31:0] b, input logic [31:0] e, output int cyc);
    @(negedge clk);
    clear_logs();
    bus.begin_clust = b;
    bus.end_clust   = e;
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < Timeout) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_total++;
    if (outs() === '0) n_pass++;
    else $display("FAIL reset_outputs: got %h want 0", outs());
    repeat (2) @(negedge clk);
    n_total++;
    if (outs() === '0) n_pass++;
    else $display("FAIL reset_held: got %h want 0", outs());
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.busy === 1'b0 && bus.done === 1'b0) n_pass++;
    else $display("FAIL reset_idle: busy=%b done=%b want 0 0", bus.busy, bus.done);
  endtask

  task automatic test_single_page();
    int cyc;
    logic [66:0] exp[$];
    logic [66:0] got;
    run_chain(32'h81, 32'hFF, cyc);
    exp.push_back(ev(0, 32'h20, 0, 0));
    exp.push_back(ev(2, 32'h81, 32'hFF, 1));
    exp.push_back(ev(1, 32'h20, 0, 0));
    exp.push_back(ev(1, 32'h3E0, 0, 0));
    n_total++;
    if (cyc < Timeout) n_pass++;
    else $display("FAIL single_page timeout: got %0d cycles want <%0d", cyc, Timeout);
    n_total++;
    if (ev_q.size() == exp.size()) n_pass++;
    else $display("FAIL single_page count: got %0d want %0d", ev_q.size(), exp.size());
    foreach (exp[i]) begin
      got = (i < int'(ev_q.size())) ? ev_q[i] : 'x;
      n_total++;
      if (got === exp[i]) n_pass++;
      else $display("FAIL single_page ev%0d: got %h want %h", i, got, exp[i]);
    end
    n_total++;
    if (viol == 0 && done_cnt == 1 && bus.err === 1'b0) n_pass++;
    else $display("FAIL single_page status: viol=%0d done=%0d err=%b want 0 1 0",
                  viol, done_cnt, bus.err);
  endtask

  task automatic test_page_cross();
    int cyc;
    logic [66:0] exp[$];
    logic [66:0] got;
    run_chain(32'h3F0, 32'h410, cyc);
    exp.push_back(ev(0, 32'h20, 0, 0));
    exp.push_back(ev(2, 32'h3F0, 32'h3FF, 0));
    exp.push_back(ev(1, 32'h20, 0, 0));
    exp.push_back(ev(1, 32'h3E0, 0, 0));
    exp.push_back(ev(0, 32'h28, 0, 0));
    exp.push_back(ev(2, 32'h400, 32'h410, 1));
    exp.push_back(ev(1, 32'h28, 0, 0));
    exp.push_back(ev(1, 32'h3E8, 0, 0));
    n_total++;
    if (ev_q.size() == exp.size() && cyc < Timeout) n_pass++;
    else $display("FAIL page_cross count: got %0d want %0d (cycles %0d)",
                  ev_q.size(), exp.size(), cyc);
    foreach (exp[i]) begin
      got = (i < int'(ev_q.size())) ? ev_q[i] : 'x;
      n_total++;
      if (got === exp[i]) n_pass++;
      else $display("FAIL page_cross ev%0d: got %h want %h", i, got, exp[i]);
    end
    n_total++;
    if (viol == 0 && done_cnt == 1 && bus.err === 1'b0) n_pass++;
    else $display("FAIL page_cross status: viol=%0d done=%0d err=%b want 0 1 0",
                  viol, done_cnt, bus.err);
  endtask

  task automatic test_errors();
    int cyc;
    logic [31:0] bv[2];
    logic [31:0] evv[2];
    bv[0] = 32'h10; evv[0] = 32'h8;
    bv[1] = 32'h1;  evv[1] = 32'h5;
    for (int k = 0; k < 2; k++) begin
      run_chain(bv[k], evv[k], cyc);
      n_total++;
      if (cyc <= 3) n_pass++;
      else $display("FAIL error%0d done_latency: got %0d want <=3", k, cyc);
      n_total++;
      if (bus.err === 1'b1 && act == 0 && done_cnt == 1 && bus.busy === 1'b0) n_pass++;
      else $display("FAIL error%0d status: err=%b act=%0d done=%0d busy=%b want 1 0 1 0",
                    k, bus.err, act, done_cnt, bus.busy);
    end
  endtask

  task automatic test_boundary();
    int cyc;
    logic [66:0] exp[$];
    logic [66:0] got;
    run_chain(32'h400, 32'h400, cyc);
    exp.push_back(ev(0, 32'h28, 0, 0));
    exp.push_back(ev(2, 32'h400, 32'h400, 1));
    exp.push_back(ev(1, 32'h28, 0, 0));
    exp.push_back(ev(1, 32'h3E8, 0, 0));
    n_total++;
    if (ev_q.size() == exp.size() && cyc < Timeout) n_pass++;
    else $display("FAIL boundary count: got %0d want %0d (cycles %0d)",
                  ev_q.size(), exp.size(), cyc);
    foreach (exp[i]) begin
      got = (i < int'(ev_q.size())) ? ev_q[i] : 'x;
      n_total++;
      if (got === exp[i]) n_pass++;
      else $display("FAIL boundary ev%0d: got %h want %h", i, got, exp[i]);
    end
    n_total++;
    if (viol == 0 && done_cnt == 1 && bus.err === 1'b0) n_pass++;
    else $display("FAIL boundary status: viol=%0d done=%0d err=%b want 0 1 0 (err cleared)",
                  viol, done_cnt, bus.err);
  endtask

  task automatic test_handshake();
    int cyc;
    logic [66:0] exp[$];
    logic [66:0] got;
    // Spurious ack while idle
    @(negedge clk);
    ack_man = 1'b1;
    @(negedge clk);
    ack_man = 1'b0;
    @(negedge clk);
    n_total++;
    if ({bus.busy, bus.done, bus.med_rd_req, bus.med_wr_req, bus.upd_ena} === 5'b0) n_pass++;
    else $display("FAIL idle_ack: got busy/done/rd/wr/ena=%b want 00000",
                  {bus.busy, bus.done, bus.med_rd_req, bus.med_wr_req, bus.upd_ena});
    med_delay = 20;
    upd_auto  = 1'b0;
    clear_logs();
    bus.begin_clust = 32'h81;
    bus.end_clust   = 32'hFF;
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.upd_ena && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_total++;
    if (cyc < 200) n_pass++;
    else $display("FAIL delayed_ack reach_update: got %0d cycles want <200", cyc);
    // Spurious ack and a second START while updating
    ack_man = 1'b1;
    bus.start = 1'b1;
    bus.begin_clust = 32'h500;
    bus.end_clust   = 32'h600;
    @(negedge clk);
    ack_man = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (bus.upd_ena === 1'b1 && bus.med_wr_req === 1'b0 && bus.upd_begin === 32'h81) n_pass++;
    else $display("FAIL update_ack_start: ena=%b wr=%b begin=%h want 1 0 81",
                  bus.upd_ena, bus.med_wr_req, bus.upd_begin);
    upd_auto = 1'b1;
    cyc = 0;
    while (!bus.done && cyc < Timeout) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    exp.push_back(ev(0, 32'h20, 0, 0));
    exp.push_back(ev(2, 32'h81, 32'hFF, 1));
    exp.push_back(ev(1, 32'h20, 0, 0));
    exp.push_back(ev(1, 32'h3E0, 0, 0));
    n_total++;
    if (ev_q.size() == exp.size() && cyc < Timeout) n_pass++;
    else $display("FAIL delayed_ack count: got %0d want %0d (cycles %0d)",
                  ev_q.size(), exp.size(), cyc);
    foreach (exp[i]) begin
      got = (i < int'(ev_q.size())) ? ev_q[i] : 'x;
      n_total++;
      if (got === exp[i]) n_pass++;
      else $display("FAIL delayed_ack ev%0d: got %h want %h", i, got, exp[i]);
    end
    n_total++;
    if (viol == 0 && rd_cycles == 21 && done_cnt == 1) n_pass++;
    else $display("FAIL delayed_ack stability: viol=%0d rd_cycles=%0d done=%0d want 0 21 1",
                  viol, rd_cycles, done_cnt);
    med_delay = 1;
  endtask

  task automatic test_reset_mid_update();
    int cyc;
    logic [66:0] exp[$];
    logic [66:0] got;
    upd_auto = 1'b0;
    @(negedge clk);
    clear_logs();
    bus.begin_clust = 32'h3F0;
    bus.end_clust   = 32'h410;
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.upd_ena && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_total++;
    if (cyc < 200) n_pass++;
    else $display("FAIL midreset reach_update: got %0d cycles want <200", cyc);
    // Assert reset between edges; outputs must clear before the next posedge.
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (outs() === '0) n_pass++;
    else $display("FAIL midreset async_clear: got %h want 0", outs());
    @(negedge clk);
    rst_n = 1'b1;
    upd_auto = 1'b1;
    run_chain(32'h81, 32'hFF, cyc);
    exp.push_back(ev(0, 32'h20, 0, 0));
    exp.push_back(ev(2, 32'h81, 32'hFF, 1));
    exp.push_back(ev(1, 32'h20, 0, 0));
    exp.push_back(ev(1, 32'h3E0, 0, 0));
    n_total++;
    if (ev_q.size() == exp.size() && cyc < Timeout) n_pass++;
    else $display("FAIL midreset count: got %0d want %0d (cycles %0d)",
                  ev_q.size(), exp.size(), cyc);
    foreach (exp[i]) begin
      got = (i < int'(ev_q.size())) ? ev_q[i] : 'x;
      n_total++;
      if (got === exp[i]) n_pass++;
      else $display("FAIL midreset ev%0d: got %h want %h", i, got, exp[i]);
    end
    n_total++;
    if (viol == 0 && done_cnt == 1 && bus.err === 1'b0) n_pass++;
    else $display("FAIL midreset status: viol=%0d done=%0d err=%b want 0 1 0",
                  viol, done_cnt, bus.err);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    med_delay = 1;
    upd_delay = 2;
    upd_auto = 1'b1;
    ack_man = 1'b0;
    bus.start = 1'b0;
    bus.begin_clust = '0;
    bus.end_clust = '0;
    clear_logs();
    test_reset();
    test_single_page();
    test_page_cross();
    test_errors();
    test_boundary();
    test_handshake();
    test_reset_mid_update();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
